r16b_bank_updnld: RTL and testbench
===================================

// Module: r16b_bank_updnld
// PURPOSE
//   Parametrised bank of NREGS up/down/load address registers: PC, SP, SI, DI
//   and future pointers in one block.
//   - Per-register load from the transfer bus.
//   - Increment/decrement by a programmable step.
//   - Sticky wrap flags per register.
//   - Tri-state read port onto XferBus; always-driven port onto the address bus.
// PARAMETERS
//   WIDTH    16  register width in bits
//   NREGS    4   number of registers in the bank (>=2)
//   STEP_W   4   width of the inc/dec step operand
//   RST_VAL  0   value loaded into every register on clr
// PORTS
//   clk        in   1                  clock; state updates on the falling edge
//   clr        in   1                  synchronous active-high reset
//   wr_sel     in   $clog2(NREGS)      register targeted by reg_load/inc/dec
//   reg_load   in   1                  load XferBusIn into bank[wr_sel]
//   inc        in   1                  bank[wr_sel] += step
//   dec        in   1                  bank[wr_sel] -= step
//   step       in   STEP_W             step amount, zero-extended to WIDTH
//   XferBusIn  in   WIDTH              load data
//   rd_sel     in   $clog2(NREGS)      register driven on Out
//   reg_write  in   1                  enable for Out
//   Out        out  WIDTH              bank[rd_sel] when reg_write=1, else 'bZ
//   addr_sel   in   $clog2(NREGS)      register driven on AddrOut
//   AddrOut    out  WIDTH              bank[addr_sel], always driven
//   wrap       out  NREGS              sticky per-register wrap flags
// BEHAVIOUR
//   - All state changes occur at negedge clk. Outputs are combinational from current state.
//   - Priority at each edge:
//     1. clr: all registers <= RST_VAL, wrap <= 0, regardless of other inputs.
//     2. reg_load: bank[wr_sel] <= XferBusIn; wrap[wr_sel] <= 0.
//     3. inc and dec both set: hold; no flag change.
//     4. inc: bank[wr_sel] <= (bank + step) mod 2^WIDTH.
//        wrap[wr_sel] <= 1 if the true sum is >= 2^WIDTH.
//     5. dec: bank[wr_sel] <= (bank - step) mod 2^WIDTH.
//        wrap[wr_sel] <= 1 if step > bank.
//   - step=0 with inc or dec: register unchanged, flag unchanged.
//   - Only bank[wr_sel] is affected; other registers and flags hold.
//   - Wrap flags are sticky: they clear only on clr or on reg_load of that register.
//   - Read-during-update: Out/AddrOut show the pre-edge value until the falling edge,
//     then the new value (zero-cycle read latency, one-edge write latency).
//   - Out is 'bZ whenever reg_write=0, including during clr.
//   - AddrOut never floats.
//   - Out-of-range selects (NREGS not a power of 2):
//     - wr_sel >= NREGS: load/inc/dec ignored.
//     - rd_sel/addr_sel >= NREGS: read 0.
//   - Power-up before the first clr: registers = RST_VAL, wrap = 0.
//   - clr asserted mid-sequence aborts any pending update on that edge. The following
//     edge proceeds normally from RST_VAL once clr is low.
// TESTING
//   - clr=1 one edge with reg_load=1, XferBusIn=16'h1234:
//     all regs 0, wrap=0, Out=Z (reg_write=0), AddrOut=0.
//   - wr_sel=1, load 16'hFFFE; then inc with step=3:
//     bank[1]=16'h0001, wrap[1]=1; other regs and flags unchanged.
//   - wr_sel=2, load 16'h0002; then dec with step=2, then dec again:
//     16'h0000 with wrap[2]=0, then 16'hFFFE with wrap[2]=1.
//     A following load of 16'h0100 clears wrap[2].
//   - inc=dec=1 on bank[0]=16'h0010: stays 16'h0010.
//     reg_load=inc=1, XferBusIn=16'h00AA: bank[0]=16'h00AA (load wins).
//   - rd_sel=addr_sel=3, reg_write=1 during inc of bank[3] from 16'h0007 by 1:
//     Out/AddrOut read 7 before negedge, 8 after. reg_write=0 -> Out=Z.
//   - NREGS=3 build: wr_sel=3 with load -> no register changes; rd_sel=3 -> Out=0.

Source files
------------

// File: rtl/r16b_bank_updnld.sv
`default_nettype none
// ============================================================================
// r16b_bank_updnld : bank of up/down/load address registers, falling-edge state
// Revision: 1.0
// ============================================================================
module r16b_bank_updnld #(
  parameter int               WIDTH   = 16,
  parameter int               NREGS   = 4,
  parameter int               STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [$clog2(NREGS)-1:0] wr_sel,
  input  logic                     reg_load,
  input  logic                     inc,
  input  logic                     dec,
  input  logic [STEP_W-1:0]        step,
  input  logic [WIDTH-1:0]         XferBusIn,
  input  logic [$clog2(NREGS)-1:0] rd_sel,
  input  logic                     reg_write,
  output logic [WIDTH-1:0]         Out,
  input  logic [$clog2(NREGS)-1:0] addr_sel,
  output logic [WIDTH-1:0]         AddrOut,
  output logic [NREGS-1:0]         wrap
);

  localparam int SEL_W = $clog2(NREGS);

  // Declaration initialisers give the power-up state before the first clr.
  logic [WIDTH-1:0] r_bank [NREGS] = '{default: RST_VAL};
  logic [NREGS-1:0] r_wrap = '0;

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] w_addr;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_sum;
  logic             w_borrow;

  // Select decode by comparison, so out-of-range selects naturally read zero.
  always_comb begin
    w_cur  = '0;
    w_rd   = '0;
    w_addr = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_sel == SEL_W'(i))   w_cur  = r_bank[i];
      if (rd_sel == SEL_W'(i))   w_rd   = r_bank[i];
      if (addr_sel == SEL_W'(i)) w_addr = r_bank[i];
    end
  end

  assign w_step   = {{(WIDTH-STEP_W){1'b0}}, step};
  assign w_sum    = {1'b0, w_cur} + {1'b0, w_step};
  assign w_borrow = (w_step > w_cur);

  always_ff @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) r_bank[i] <= RST_VAL;
      r_wrap <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          if (reg_load) begin
            r_bank[i] <= XferBusIn;
            r_wrap[i] <= 1'b0;
          end else if (inc && !dec) begin
            r_bank[i] <= w_sum[WIDTH-1:0];
            if (w_sum[WIDTH]) r_wrap[i] <= 1'b1;
          end else if (dec && !inc) begin
            r_bank[i] <= w_cur - w_step;
            if (w_borrow) r_wrap[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign Out     = reg_write ? w_rd : {WIDTH{1'bz}};
  assign AddrOut = w_addr;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_r16b_bank_updnld.sv
`default_nettype none
// ============================================================================
// tb_r16b_bank_updnld : randomized scoreboard bench for r16b_bank_updnld
// Revision: 1.0
// ============================================================================
module tb_r16b_bank_updnld;

  logic        clk = 1'b0;
  logic        clr, reg_load, inc, dec, reg_write;
  logic [1:0]  wr_sel, rd_sel, addr_sel;
  logic [3:0]  step;
  logic [15:0] xin;
  wire  [15:0] out_w;
  wire  [15:0] addr_w;
  wire  [3:0]  wrap_w;

  logic        clr3, load3, rw3;
  logic [1:0]  wr3, rd3, as3;
  logic [15:0] xin3;
  wire  [15:0] out3;
  wire  [15:0] addr3;
  wire  [2:0]  wrap3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] out;
    logic [15:0] addr;
    logic [3:0]  wrap;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  // Reference state: plain integers, no bit-level carry logic.
  int   m_bank[4];
  bit   m_wrap[4];

  always #5 clk = ~clk;

  r16b_bank_updnld dut (
    .clk(clk), .clr(clr), .wr_sel(wr_sel), .reg_load(reg_load), .inc(inc),
    .dec(dec), .step(step), .XferBusIn(xin), .rd_sel(rd_sel),
    .reg_write(reg_write), .Out(out_w), .addr_sel(addr_sel),
    .AddrOut(addr_w), .wrap(wrap_w)
  );

  r16b_bank_updnld #(.NREGS(3)) dut3 (
    .clk(clk), .clr(clr3), .wr_sel(wr3), .reg_load(load3), .inc(1'b0),
    .dec(1'b0), .step(4'd0), .XferBusIn(xin3), .rd_sel(rd3),
    .reg_write(rw3), .Out(out3), .addr_sel(as3), .AddrOut(addr3),
    .wrap(wrap3)
  );

  task automatic check16(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [3:0] wrap_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_wrap[i];
    return v;
  endfunction

  // One transaction: drive, predict the pre-edge view, then apply the rules.
  task automatic txn(string tag, bit c, int w, bit ld, bit up, bit dn, int st,
                     int x, int r, bit rw, int a);
    exp_t e;
    @(posedge clk); #1;
    clr = c; wr_sel = 2'(w); reg_load = ld; inc = up; dec = dn;
    step = 4'(st); xin = 16'(x); rd_sel = 2'(r); reg_write = rw; addr_sel = 2'(a);
    e.out  = rw ? 16'(m_bank[r]) : 16'hzzzz;
    e.addr = 16'(m_bank[a]);
    e.wrap = wrap_vec();
    e.tag  = tag;
    sbq.push_back(e);
    if (c) begin
      for (int i = 0; i < 4; i++) begin m_bank[i] = 0; m_wrap[i] = 0; end
    end else if (ld) begin
      m_bank[w] = x & 16'hFFFF; m_wrap[w] = 0;
    end else if (up && !dn) begin
      int s = m_bank[w] + st;
      if (s >= 65536) begin m_wrap[w] = 1; s -= 65536; end
      m_bank[w] = s;
    end else if (dn && !up) begin
      int d = m_bank[w] - st;
      if (d < 0) begin m_wrap[w] = 1; d += 65536; end
      m_bank[w] = d;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check16({e.tag, "_out"},  out_w,  e.out);
        check16({e.tag, "_addr"}, addr_w, e.addr);
        check16({e.tag, "_wrap"}, {12'd0, wrap_w}, {12'd0, e.wrap});
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 4; i++) begin m_bank[i] = 0; m_wrap[i] = 0; end
    clr = 0; wr_sel = 0; reg_load = 0; inc = 0; dec = 0; step = 0; xin = 0;
    rd_sel = 0; reg_write = 0; addr_sel = 0;
    clr3 = 0; load3 = 0; rw3 = 0; wr3 = 0; rd3 = 0; as3 = 0; xin3 = 0;

    // power-up view, then clr overriding a load
    txn("pwrup", 0, 0, 0, 0, 0, 0, 0,       0, 1, 1);
    txn("clr",   1, 0, 1, 0, 0, 0, 'h1234,  0, 0, 0);
    txn("rst",   0, 0, 0, 0, 0, 0, 0,       0, 0, 0);
    // increment wrap on reg 1
    txn("ld1",   0, 1, 1, 0, 0, 0, 'hFFFE,  1, 1, 1);
    txn("inc1",  0, 1, 0, 1, 0, 3, 0,       1, 1, 1);
    txn("chk1",  0, 0, 0, 0, 0, 0, 0,       1, 1, 0);
    // decrement to zero, then underflow, then load clears the flag
    txn("ld2",   0, 2, 1, 0, 0, 0, 'h0002,  2, 1, 2);
    txn("dec2a", 0, 2, 0, 0, 1, 2, 0,       2, 1, 2);
    txn("dec2b", 0, 2, 0, 0, 1, 2, 0,       2, 1, 2);
    txn("ld2b",  0, 2, 1, 0, 0, 0, 'h0100,  2, 1, 2);
    txn("chk2",  0, 0, 0, 0, 0, 0, 0,       2, 1, 2);
    // inc+dec holds; load beats inc; step 0 is a no-op
    txn("ld0",   0, 0, 1, 0, 0, 0, 'h0010,  0, 1, 0);
    txn("incdec",0, 0, 0, 1, 1, 5, 0,       0, 1, 0);
    txn("ldinc", 0, 0, 1, 1, 0, 7, 'h00AA,  0, 1, 0);
    txn("step0", 0, 0, 0, 1, 0, 0, 0,       0, 1, 0);
    // read-during-update on reg 3, then Out released
    txn("ld3",   0, 3, 1, 0, 0, 0, 'h0007,  3, 1, 3);
    txn("inc3",  0, 3, 0, 1, 0, 1, 0,       3, 1, 3);
    txn("post3", 0, 0, 0, 0, 0, 0, 0,       3, 1, 3);
    txn("outz",  0, 0, 0, 0, 0, 0, 0,       3, 0, 3);

    for (int n = 0; n < 400; n++) begin
      int  k  = $urandom_range(0, 99);
      bit  c  = (k < 3);
      bit  ld = (k >= 3 && k < 20);
      txn("rnd", c, $urandom_range(0, 3), ld, 1'($urandom), 1'($urandom),
          $urandom_range(0, 15),
          (k < 12) ? 'hFFF0 + $urandom_range(0, 15) : $urandom_range(0, 65535),
          $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end

    // NREGS=3 build: out-of-range write ignored, out-of-range read is zero
    @(posedge clk); #1; clr3 = 1;
    @(posedge clk); #1; clr3 = 0; load3 = 1; wr3 = 0; xin3 = 16'h0055;
    @(posedge clk); #1; wr3 = 3; xin3 = 16'hBEEF;
    @(posedge clk); #1; load3 = 0; rd3 = 3; rw3 = 1; as3 = 3;
    #2;
    check16("n3_out_oor",  out3,  16'h0000);
    check16("n3_addr_oor", addr3, 16'h0000);
    @(posedge clk); #1; rd3 = 0; as3 = 1;
    #2;
    check16("n3_reg0",  out3,  16'h0055);
    check16("n3_reg1",  addr3, 16'h0000);
    @(posedge clk); #1; rd3 = 2; as3 = 2;
    #2;
    check16("n3_reg2",  out3,  16'h0000);
    check16("n3_wrap",  {13'd0, wrap3}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
